// File: rtl/bridge_ic_pkg.sv
// Shared constants and helpers for the bridge_ic device bridge and
// its interrupt controller.
package bridge_ic_pkg;

   localparam int NSRC = 6;

   localparam logic [31:0] T0_BASE  = 32'h0000_7f00;
   localparam logic [31:0] T1_BASE  = 32'h0000_7f10;
   localparam logic [31:0] IC_BASE  = 32'h0000_7f20;
   localparam logic [31:0] WIN_LAST = 32'd11;

   localparam logic [3:0] OFF_PEND = 4'd0;
   localparam logic [3:0] OFF_MASK = 4'd4;
   localparam logic [3:0] OFF_MODE = 4'd8;

   typedef enum logic [1:0] {
      REG_PEND,
      REG_MASK,
      REG_MODE,
      REG_NONE
   } ic_reg_e;

   function automatic logic in_win(
      input logic [31:0] addr,
      input logic [31:0] base
   );
      return (addr >= base) && (addr <= base + WIN_LAST);
   endfunction

   // Word select within the IC window; byte lanes of a word alias to it
   function automatic ic_reg_e reg_sel(input logic [3:0] off);
      ic_reg_e r;
      r = REG_NONE;
      if (off[3:2] == OFF_PEND[3:2]) r = REG_PEND;
      if (off[3:2] == OFF_MASK[3:2]) r = REG_MASK;
      if (off[3:2] == OFF_MODE[3:2]) r = REG_MODE;
      return r;
   endfunction

endpackage

// File: rtl/ic_cell.sv
// One interrupt source: input sampler, pending latch, mask/mode bits
// and the registered interrupt line.
module ic_cell (
   input  logic clk,
   input  logic reset,
   input  logic irq_i,
   input  logic wd_i,
   input  logic pend_we_i,
   input  logic mask_we_i,
   input  logic mode_we_i,
   output logic pend_o,
   output logic mask_o,
   output logic mode_o,
   output logic hwint_o
);

   logic irq_q;
   logic pend_q, pend_d;
   logic mask_q, mask_d;
   logic mode_q, mode_d;
   logic hwint_q, hwint_d;
   logic set_s;

   // A new set beats a same-cycle write-1-to-clear
   always_comb begin
      set_s   = mode_q ? (irq_i & ~irq_q) : irq_i;
      pend_d  = set_s | (pend_q & ~(pend_we_i & wd_i));
      mask_d  = mask_we_i ? wd_i : mask_q;
      mode_d  = mode_we_i ? wd_i : mode_q;
      hwint_d = pend_q & mask_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q   <= 1'b0;
         pend_q  <= 1'b0;
         mask_q  <= 1'b0;
         mode_q  <= 1'b0;
         hwint_q <= 1'b0;
      end else begin
         irq_q   <= irq_i;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         hwint_q <= hwint_d;
      end
   end

   assign pend_o  = pend_q;
   assign mask_o  = mask_q;
   assign mode_o  = mode_q;
   assign hwint_o = hwint_q;

endmodule

// File: rtl/bridge_ic.sv
// CPU-side device bridge: address decode for two timers plus a local
// interrupt controller, with a combinational read-back mux.
module bridge_ic
   import bridge_ic_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      PrAddr,
   input  logic [31:0]      PrWD,
   input  logic [3:0]       PrBE,
   input  logic             PrWe,
   output logic [31:0]      PrRD,
   output logic [31:0]      DevAddr,
   output logic [31:0]      DevWD,
   output logic             T0_We,
   output logic             T1_We,
   input  logic [31:0]      T0_RD,
   input  logic [31:0]      T1_RD,
   input  logic [NSRC-1:0]  irq_in,
   output logic [NSRC-1:0]  HWInt
);

   logic            t0_hit;
   logic            t1_hit;
   logic            ic_hit;
   logic            ic_we;
   logic [3:0]      ic_off;
   ic_reg_e         sel;
   logic            pend_we;
   logic            mask_we;
   logic            mode_we;
   logic [NSRC-1:0] pend_v;
   logic [NSRC-1:0] mask_v;
   logic [NSRC-1:0] mode_v;
   logic [31:0]     ic_rd;

   assign t0_hit = in_win(PrAddr, T0_BASE);
   assign t1_hit = in_win(PrAddr, T1_BASE);
   assign ic_hit = in_win(PrAddr, IC_BASE);

   assign DevAddr = PrAddr;
   assign DevWD   = PrWD;
   assign T0_We   = PrWe & t0_hit;
   assign T1_We   = PrWe & t1_hit;

   // Partial-word writes never touch IC state
   assign ic_off  = PrAddr[3:0] - IC_BASE[3:0];
   assign sel     = reg_sel(ic_off);
   assign ic_we   = PrWe & ic_hit & (PrBE == 4'b1111);
   assign pend_we = ic_we & (sel == REG_PEND);
   assign mask_we = ic_we & (sel == REG_MASK);
   assign mode_we = ic_we & (sel == REG_MODE);

   for (genvar g = 0; g < NSRC; g++) begin : g_cell
      ic_cell u_cell (
         .clk       (clk),
         .reset     (reset),
         .irq_i     (irq_in[g]),
         .wd_i      (PrWD[g]),
         .pend_we_i (pend_we),
         .mask_we_i (mask_we),
         .mode_we_i (mode_we),
         .pend_o    (pend_v[g]),
         .mask_o    (mask_v[g]),
         .mode_o    (mode_v[g]),
         .hwint_o   (HWInt[g])
      );
   end

   always_comb begin
      ic_rd = 32'd0;
      unique case (sel)
         REG_PEND: ic_rd[NSRC-1:0] = pend_v;
         REG_MASK: ic_rd[NSRC-1:0] = mask_v;
         REG_MODE: ic_rd[NSRC-1:0] = mode_v;
         default:  ic_rd = 32'd0;
      endcase
   end

   always_comb begin
      PrRD = 32'd0;
      unique case (1'b1)
         t0_hit:  PrRD = T0_RD;
         t1_hit:  PrRD = T1_RD;
         ic_hit:  PrRD = ic_rd;
         default: PrRD = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_bridge_ic.sv
// Scoreboard bench for bridge_ic: directed scenarios followed by
// random traffic against a behavioural model of the bridge.
module tb_bridge_ic;
   import bridge_ic_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PrAddr, PrWD, PrRD, DevAddr, DevWD, T0_RD, T1_RD;
   logic [3:0]  PrBE;
   logic        PrWe, T0_We, T1_We;
   logic [5:0]  irq_in, HWInt;

   always #5 clk = ~clk;

   bridge_ic dut (
      .clk     (clk),
      .reset   (reset),
      .PrAddr  (PrAddr),
      .PrWD    (PrWD),
      .PrBE    (PrBE),
      .PrWe    (PrWe),
      .PrRD    (PrRD),
      .DevAddr (DevAddr),
      .DevWD   (DevWD),
      .T0_We   (T0_We),
      .T1_We   (T1_We),
      .T0_RD   (T0_RD),
      .T1_RD   (T1_RD),
      .irq_in  (irq_in),
      .HWInt   (HWInt)
   );

   typedef struct {
      int          cyc;
      int          kind;
      string       nm;
      logic [31:0] rd;
      logic        t0;
      logic        t1;
      logic [5:0]  hw;
      logic [31:0] da;
      logic [31:0] dwd;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic [5:0] m_pend, m_mask, m_mode, m_prev, m_hw;
   logic [5:0] irq_cur;

   function automatic logic hit(input logic [31:0] a, input logic [31:0] b);
      return (a >= b) && (a <= b + 32'd11);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] off;
      if (hit(a, T0_BASE)) return T0_RD;
      if (hit(a, T1_BASE)) return T1_RD;
      if (hit(a, IC_BASE)) begin
         off = a - IC_BASE;
         if (off == 0) return {26'd0, m_pend};
         if (off == 4) return {26'd0, m_mask};
         if (off == 8) return {26'd0, m_mode};
      end
      return 32'd0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   // Monitor: pops every expectation queued for the current cycle
   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         e = sbq.pop_front();
         case (e.kind)
            0: begin
               chk("PrRD",    PrRD,                e.rd);
               chk("T0_We",   {31'd0, T0_We},      {31'd0, e.t0});
               chk("T1_We",   {31'd0, T1_We},      {31'd0, e.t1});
               chk("HWInt",   {26'd0, HWInt},      {26'd0, e.hw});
               chk("DevAddr", DevAddr,             e.da);
               chk("DevWD",   DevWD,               e.dwd);
            end
            1:       chk(e.nm, PrRD, e.rd);
            default: chk(e.nm, {26'd0, HWInt}, {26'd0, e.hw});
         endcase
      end
   end

   task automatic expect_c(input int kind, input string nm,
                           input logic [31:0] v);
      exp_t e;
      e = '{cyc: cyc, kind: kind, nm: nm, rd: v, t0: 1'b0, t1: 1'b0,
            hw: v[5:0], da: 32'd0, dwd: 32'd0};
      sbq.push_back(e);
   endtask

   task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic we,
                             input logic [5:0] irq, input logic rst);
      logic [5:0]  setv, clr, n_hw;
      logic [31:0] off;
      logic        icw;
      if (rst) begin
         m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_hw = 0;
         return;
      end
      icw  = we && hit(a, IC_BASE) && be == 4'hf;
      off  = a - IC_BASE;
      setv = (m_mode & irq & ~m_prev) | (~m_mode & irq);
      clr  = (icw && off == 0) ? wd[5:0] : 6'd0;
      n_hw = m_pend & m_mask;
      m_pend = setv | (m_pend & ~clr);
      if (icw && off == 4) m_mask = wd[5:0];
      if (icw && off == 8) m_mode = wd[5:0];
      m_prev = irq;
      m_hw   = n_hw;
   endtask

   task automatic tick(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic we,
                       input logic [5:0] irq, input logic rst);
      exp_t e;
      PrAddr = a; PrWD = wd; PrBE = be; PrWe = we;
      irq_in = irq; reset = rst;
      T0_RD  = $urandom; T1_RD = $urandom;
      e.cyc = cyc; e.kind = 0; e.nm = "model";
      e.rd  = m_read(a);
      e.t0  = we & hit(a, T0_BASE);
      e.t1  = we & hit(a, T1_BASE);
      e.hw  = m_hw;
      e.da  = a;
      e.dwd = wd;
      sbq.push_back(e);
      @(posedge clk);
      model_step(a, wd, be, we, irq, rst);
      cyc++;
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      tick(a, d, 4'hf, 1'b1, irq_cur, 1'b0);
   endtask

   task automatic rd(input logic [31:0] a);
      tick(a, 32'd0, 4'hf, 1'b0, irq_cur, 1'b0);
   endtask

   logic [31:0] misses [6];

   initial begin
      logic [31:0] a;
      logic [3:0]  be;
      misses = '{32'h7f0c, 32'h7f1c, 32'h7f2c, 32'h7f30, 32'h7eff, 32'h0};
      irq_cur = 0;
      m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_hw = 0;
      @(posedge clk); #1;
      tick(32'h0, 32'h0, 4'h0, 1'b1, 6'h3f, 1'b1);
      tick(32'h7f20, 32'h3f, 4'hf, 1'b1, 6'h3f, 1'b1);

      expect_c(2, "rst_hw", 0); expect_c(1, "rst_pend", 0);
      rd(IC_BASE);
      expect_c(1, "rst_mask", 0);
      rd(IC_BASE + 4);

      tick(32'h7f04, 32'h55, 4'hf, 1'b1, irq_cur, 1'b0);
      tick(32'h7f14, 32'h55, 4'hf, 1'b1, irq_cur, 1'b0);
      expect_c(1, "miss_rd", 0);
      rd(32'h7f30);
      tick(32'h7f30, 32'hffff_ffff, 4'hf, 1'b1, irq_cur, 1'b0);
      expect_c(1, "miss_mask", 0);
      rd(32'h7f24);

      wr(32'h7f24, 1); wr(32'h7f28, 1);
      irq_cur = 6'h01;
      rd(32'h7f00);
      expect_c(1, "edge_pend", 1);
      rd(32'h7f20);
      expect_c(2, "edge_hw", 1);
      rd(32'h7f20);
      wr(32'h7f20, 1);
      expect_c(1, "edge_w1c", 0);
      rd(32'h7f20);
      for (int i = 0; i < 3; i++) begin
         expect_c(2, "edge_hw_off", 0);
         rd(32'h7f20);
      end

      irq_cur = 6'h04;
      wr(32'h7f28, 0); wr(32'h7f24, 4);
      wr(32'h7f20, 4);
      expect_c(1, "lvl_hold", 4);
      rd(32'h7f20);
      irq_cur = 6'h00;
      rd(32'h7f20);
      wr(32'h7f20, 4);
      expect_c(1, "lvl_clr", 0);
      rd(32'h7f20);
      expect_c(2, "lvl_hw", 0);
      rd(32'h7f20);

      wr(32'h7f28, 2); wr(32'h7f24, 2);
      rd(32'h7f20);
      irq_cur = 6'h02;
      wr(32'h7f20, 2);
      expect_c(1, "set_wins", 2);
      rd(32'h7f20);
      tick(32'h7f24, 32'h0, 4'b0011, 1'b1, irq_cur, 1'b0);
      expect_c(1, "be_ignored", 2);
      rd(32'h7f24);

      wr(32'h7f28, 0); wr(32'h7f24, 32'h3f);
      irq_cur = 6'h3f;
      rd(32'h7f20); rd(32'h7f20);
      expect_c(2, "all_hw", 32'h3f);
      rd(32'h7f20);
      tick(32'h7f20, 32'h0, 4'hf, 1'b0, irq_cur, 1'b1);
      expect_c(2, "rst_hw2", 0); expect_c(1, "rst_pend2", 0);
      rd(32'h7f20);
      expect_c(1, "rst_mask2", 0);
      rd(32'h7f24);

      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 4))
            0:       a = T0_BASE + 32'($urandom_range(0, 11));
            1:       a = T1_BASE + 32'($urandom_range(0, 11));
            2, 3:    a = IC_BASE + 32'(4 * $urandom_range(0, 2));
            default: a = misses[$urandom_range(0, 5)];
         endcase
         be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
         for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 7) == 0) irq_cur[b] = ~irq_cur[b];
         tick(a, $urandom, be, 1'($urandom), irq_cur,
              $urandom_range(0, 99) < 2);
      end

      @(negedge clk);
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain left=%0d", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bridge_ic.md
BRIDGE_IC -- requirements
Module: bridge_ic

Interface
REQ-001 NSRC, 6, number of interrupt sources; fixed at 6 to match HWInt[7:2].
REQ-002 T0_BASE, 32'h00007f00, Timer0 window base, 12 bytes.
REQ-003 T1_BASE, 32'h00007f10, Timer1 window base, 12 bytes.
REQ-004 IC_BASE, 32'h00007f20, interrupt-controller window base, 12 bytes.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 PrAddr  in  32  CPU device address.
REQ-008 PrWD  in  32  CPU write data.
REQ-009 PrBE  in  4  CPU byte enables.
REQ-010 PrWe  in  1  CPU device write strobe.
REQ-011 PrRD  out  32  read data to CPU, combinational.
REQ-012 DevAddr  out  32  PrAddr forwarded to timers.
REQ-013 DevWD  out  32  PrWD forwarded to timers.
REQ-014 T0_We / T1_We  out  1 each  timer write strobes.
REQ-015 T0_RD / T1_RD  in  32 each  timer read data.
REQ-016 irq_in  in  6  raw sources: [0] Timer0, [1] Timer1, [5:2] external.
REQ-017 HWInt  out  6  registered interrupt lines to CP0 (bit i drives HWInt[i+2]).

Function
REQ-018 Decode: a window hits when PrAddr is in [BASE, BASE+11]; at most one window hits.
REQ-019 T0_We = PrWe & t0_hit; T1_We = PrWe & t1_hit; both 0 on a miss.
REQ-020 PrRD: T0_RD on t0_hit, T1_RD on t1_hit, IC register on ic_hit, 32'd0 otherwise.
REQ-021 IC registers: PEND at +0 (read, write-1-to-clear), MASK at +4 (RW), MODE at +8 (RW; bit=1 edge, 0 level); bits [31:6] read 0.
REQ-022 IC writes take effect at the next rising edge and only when PrWe & ic_hit & PrBE==4'b1111; other PrBE values are ignored.
REQ-023 irq_q is the irq_in sampled each cycle; edge_i = irq_in[i] & ~irq_q[i].
REQ-024 Edge mode: PEND[i] sets on the edge after a cycle with edge_i=1.
REQ-025 Level mode: PEND[i] sets on every edge where irq_in[i]=1.
REQ-026 Set and W1C on PEND[i] in the same cycle: set wins.
REQ-027 W1C on a level-mode bit whose source is still high: the bit stays set.
REQ-028 HWInt is registered as PEND & MASK, updated every cycle.
REQ-029 Latency: irq_in rise in cycle n gives PEND in cycle n+1 and HWInt in cycle n+2.
REQ-030 MASK write clearing bit i drops HWInt[i] one cycle after the write edge; PEND[i] is kept.
REQ-031 A MODE change takes effect from the next cycle; PEND is not altered.
REQ-032 A PEND read returns the value before any same-cycle write.

Reset
REQ-033 On reset, PEND, MASK, MODE, irq_q and HWInt are all 0.
REQ-034 A write or set condition in the reset cycle is ignored; the first update happens in the cycle after reset deasserts.
REQ-035 Reset asserted mid-operation drops HWInt to 0 on the same edge.
REQ-036 A source held high through reset, in edge mode, does not set PEND after release until it falls and rises again.

Structure
REQ-037 The shared package holds the window base constants, the IC register offsets (0/4/8) and NSRC.
REQ-038 Per-source pending, edge and mask logic is one sub-module, ic_cell, instantiated NSRC times.
REQ-039 Decode and the read mux stay in bridge_ic.

Verification
REQ-040 Timer0 write: PrAddr=0x7f04, PrWe=1, PrWD=0x55 -> T0_We=1, T1_We=0, DevWD=0x55; PrAddr=0x7f14 -> T1_We=1 only.
REQ-041 Miss: PrAddr=0x7f30 read -> PrRD=0; write -> no strobe, no IC state change.
REQ-042 Edge source: MASK=0x01, MODE=0x01, irq_in[0] rises at cycle 10 and holds -> PEND=0x01 at cycle 11, HWInt=0x01 at 12; write PEND=0x01 -> HWInt=0 two cycles later and stays 0 while the source holds.
REQ-043 Level source: MODE=0, MASK=0x04, irq_in[2]=1 held; W1C PEND=0x04 -> PEND stays 0x04; drop irq_in[2], then W1C -> PEND=0, HWInt=0 next cycle.
REQ-044 Simultaneous events: W1C on PEND[1] in the same cycle as a new Timer1 edge -> PEND[1]=1 afterwards; PrBE=4'b0011 write to MASK -> MASK unchanged.
REQ-045 Reset mid-operation: HWInt=0x3f, assert reset one cycle -> all registers 0 next edge, PrRD at 0x7f20=0.
